// File: rtl/buffer_controller_pkg.sv
// buffer_controller_pkg: states, command bit positions and effective-count helpers for the acquisition sequencer
package buffer_controller_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_PRETRIG,
      S_WAIT_TRIG,
      S_POSTTRIG,
      S_DONE,
      S_SEND_CH1,
      S_SEND_CH2
   } state_e;
   localparam int CMD_START      = 0;
   localparam int CMD_STOP       = 1;
   localparam int CMD_READ_CH1   = 2;
   localparam int CMD_READ_CH2   = 3;
   localparam int CMD_FORCE_TRIG = 4;
   function automatic logic [15:0] eff_num(input logic [15:0] n);
      return (n == 16'd0) ? 16'd1 : n;
   endfunction
   function automatic logic [15:0] eff_pt(input logic [15:0] pt, input logic [15:0] num);
      return (pt > num - 16'd1) ? num - 16'd1 : pt;
   endfunction
endpackage

// File: rtl/buffer_controller_reg.sv
// buffer_controller_reg: one addressable 16-bit configuration register on the register bus
module buffer_controller_reg #(
   parameter int          ADDR_WIDTH  = 8,
   parameter int          DATA_WIDTH  = 16,
   parameter int          ADDR        = 0,
   parameter logic [15:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  rdy_i,
   output logic [15:0]           value_o
);
   logic [15:0] value_q;
   // capture the bus word when our address is written
   always_ff @(posedge clk) begin
      if (rst) value_q <= RESET_VALUE;
      else if (rdy_i && addr_i == ADDR_WIDTH'(ADDR)) value_q <= 16'(data_i);
   end
   assign value_o = value_q;
endmodule

// File: rtl/buffer_controller.sv
// buffer_controller: capture sequencer (pre/post trigger fill) and CH1/CH2 readout onto one Tx stream
module buffer_controller
   import buffer_controller_pkg::*;
#(
   parameter int          REG_ADDR_WIDTH      = 8,
   parameter int          REG_DATA_WIDTH      = 16,
   parameter int          TX_DATA_WIDTH       = 8,
   parameter int          ADDR_REQUESTS       = 5,
   parameter int          ADDR_NUM_SAMPLES    = 6,
   parameter int          ADDR_PRETRIGGER     = 7,
   parameter logic [15:0] DEFAULT_NUM_SAMPLES = 16'd1024,
   parameter logic [15:0] DEFAULT_PRETRIGGER  = 16'd0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] register_addr,
   input  logic [REG_DATA_WIDTH-1:0] register_data,
   input  logic                      register_rdy,
   input  logic                      adc_rdy_i,
   input  logic                      trigger_i,
   output logic                      we,
   output logic                      rqst_ch1,
   output logic                      rqst_ch2,
   output logic [15:0]               num_samples,
   input  logic [TX_DATA_WIDTH-1:0]  tx_data_ch1,
   input  logic [TX_DATA_WIDTH-1:0]  tx_data_ch2,
   input  logic                      tx_rdy_ch1,
   input  logic                      tx_rdy_ch2,
   input  logic                      tx_eof_ch1,
   input  logic                      tx_eof_ch2,
   output logic                      tx_ack_ch1,
   output logic                      tx_ack_ch2,
   output logic [TX_DATA_WIDTH-1:0]  tx_data,
   output logic                      tx_rdy,
   output logic                      tx_eof,
   input  logic                      tx_ack,
   output logic                      buffer_full,
   output logic                      busy
);
   state_e      state_q, state_d;
   logic [15:0] num_reg, pt_reg, num_eff, pt_eff;
   logic [15:0] num_q, num_d, pt_q, pt_d, cnt_q, cnt_d, post, cnt_inc;
   logic        pend_q, pend_d, bf_q, bf_d, we_q, rqst1_q, rqst2_q;
   logic [4:0]  cmd;
   logic        start, stop, rd1, rd2, force_trig, in1, in2;

   buffer_controller_reg #(
      .ADDR_WIDTH(REG_ADDR_WIDTH), .DATA_WIDTH(REG_DATA_WIDTH),
      .ADDR(ADDR_NUM_SAMPLES), .RESET_VALUE(DEFAULT_NUM_SAMPLES)
   ) u_num_reg (
      .clk(clk), .rst(rst), .addr_i(register_addr), .data_i(register_data),
      .rdy_i(register_rdy), .value_o(num_reg)
   );

   buffer_controller_reg #(
      .ADDR_WIDTH(REG_ADDR_WIDTH), .DATA_WIDTH(REG_DATA_WIDTH),
      .ADDR(ADDR_PRETRIGGER), .RESET_VALUE(DEFAULT_PRETRIGGER)
   ) u_pt_reg (
      .clk(clk), .rst(rst), .addr_i(register_addr), .data_i(register_data),
      .rdy_i(register_rdy), .value_o(pt_reg)
   );

   assign cmd        = (register_rdy && register_addr == REG_ADDR_WIDTH'(ADDR_REQUESTS)) ? register_data[4:0] : '0;
   assign stop       = cmd[CMD_STOP];
   assign start      = cmd[CMD_START];
   assign rd1        = cmd[CMD_READ_CH1];
   assign rd2        = cmd[CMD_READ_CH2];
   assign force_trig = cmd[CMD_FORCE_TRIG];
   assign num_eff    = eff_num(num_reg);
   assign pt_eff     = eff_pt(pt_reg, num_eff);
   assign post       = num_q - pt_q;
   assign cnt_inc    = cnt_q + 16'd1;
   assign in1        = state_q == S_SEND_CH1;
   assign in2        = state_q == S_SEND_CH2;

   // next-state, sample counter, latched counts and pending second readout
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      bf_d    = bf_q;
      num_d   = num_q;
      pt_d    = pt_q;
      if (stop) begin
         state_d = S_IDLE;
         pend_d  = 1'b0;
         bf_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d = (pt_eff == 16'd0) ? S_WAIT_TRIG : S_PRETRIG;
                  cnt_d   = '0;
                  bf_d    = 1'b0;
                  num_d   = num_eff;
                  pt_d    = pt_eff;
               end else if (state_q == S_DONE && (rd1 || rd2)) begin
                  state_d = rd1 ? S_SEND_CH1 : S_SEND_CH2;
                  pend_d  = rd1 && rd2;
               end
            end
            S_PRETRIG: begin
               if (adc_rdy_i) begin
                  cnt_d = (cnt_inc == pt_q) ? '0 : cnt_inc;
                  state_d = (cnt_inc == pt_q) ? S_WAIT_TRIG : S_PRETRIG;
               end
            end
            S_WAIT_TRIG: begin
               if (trigger_i || force_trig) begin
                  cnt_d   = {15'd0, adc_rdy_i};
                  state_d = (adc_rdy_i && post == 16'd1) ? S_DONE : S_POSTTRIG;
                  bf_d    = adc_rdy_i && post == 16'd1;
               end
            end
            S_POSTTRIG: begin
               if (adc_rdy_i) begin
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == post) ? S_DONE : S_POSTTRIG;
                  bf_d    = cnt_inc == post;
               end
            end
            S_SEND_CH1: begin
               if (tx_rdy_ch1 && tx_eof_ch1 && tx_ack) begin
                  state_d = pend_q ? S_SEND_CH2 : S_DONE;
                  pend_d  = 1'b0;
               end
            end
            S_SEND_CH2: state_d = (tx_rdy_ch2 && tx_eof_ch2 && tx_ack) ? S_DONE : S_SEND_CH2;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // state and registered strobes; we/rqst are derived from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         bf_q    <= 1'b0;
         num_q   <= DEFAULT_NUM_SAMPLES;
         pt_q    <= DEFAULT_PRETRIGGER;
         we_q    <= 1'b0;
         rqst1_q <= 1'b0;
         rqst2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         bf_q    <= bf_d;
         num_q   <= num_d;
         pt_q    <= pt_d;
         we_q    <= state_d inside {S_PRETRIG, S_WAIT_TRIG, S_POSTTRIG};
         rqst1_q <= state_d == S_SEND_CH1 && state_q != S_SEND_CH1;
         rqst2_q <= state_d == S_SEND_CH2 && state_q != S_SEND_CH2;
      end
   end

   assign we          = we_q;
   assign rqst_ch1    = rqst1_q;
   assign rqst_ch2    = rqst2_q;
   assign num_samples = num_q;
   assign buffer_full = bf_q;
   assign busy        = !(state_q inside {S_IDLE, S_DONE});
   assign tx_data     = in2 ? tx_data_ch2 : in1 ? tx_data_ch1 : '0;
   assign tx_rdy      = (in1 && tx_rdy_ch1) || (in2 && tx_rdy_ch2);
   assign tx_eof      = (in1 && tx_eof_ch1) || (in2 && tx_eof_ch2);
   assign tx_ack_ch1  = in1 && tx_ack;
   assign tx_ack_ch2  = in2 && tx_ack;
endmodule

// File: tb/tb_buffer_controller.sv
// tb_buffer_controller: directed capture/readout scenarios with an event scoreboard
module tb_buffer_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  register_addr = '0;
   logic [15:0] register_data = '0;
   logic        register_rdy = 1'b0;
   logic        adc_rdy_i = 1'b0;
   logic        trigger_i = 1'b0;
   logic        we, rqst_ch1, rqst_ch2, tx_ack_ch1, tx_ack_ch2, tx_rdy, tx_eof, buffer_full, busy;
   logic [15:0] num_samples;
   logic [7:0]  tx_data_ch1, tx_data_ch2, tx_data;
   logic        tx_rdy_ch1, tx_rdy_ch2, tx_eof_ch1, tx_eof_ch2;
   logic        tx_ack = 1'b1;
   int          checks = 0;
   int          errors = 0;

   typedef struct {int kind; logic [7:0] val;} ev_t;
   ev_t exp_q[$];
   localparam int EV_R1 = 1, EV_R2 = 2, EV_TX = 3, EV_BF = 4;

   always #5 clk = ~clk;

   buffer_controller dut (
      .clk(clk), .rst(rst), .register_addr(register_addr), .register_data(register_data),
      .register_rdy(register_rdy), .adc_rdy_i(adc_rdy_i), .trigger_i(trigger_i), .we(we),
      .rqst_ch1(rqst_ch1), .rqst_ch2(rqst_ch2), .num_samples(num_samples),
      .tx_data_ch1(tx_data_ch1), .tx_data_ch2(tx_data_ch2), .tx_rdy_ch1(tx_rdy_ch1),
      .tx_rdy_ch2(tx_rdy_ch2), .tx_eof_ch1(tx_eof_ch1), .tx_eof_ch2(tx_eof_ch2),
      .tx_ack_ch1(tx_ack_ch1), .tx_ack_ch2(tx_ack_ch2), .tx_data(tx_data), .tx_rdy(tx_rdy),
      .tx_eof(tx_eof), .tx_ack(tx_ack), .buffer_full(buffer_full), .busy(busy)
   );

   // channel models: 4-byte streams started by rqst, advanced by their own ack
   logic [7:0] ch1_bytes [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
   logic [7:0] ch2_bytes [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
   logic [1:0] idx1 = '0, idx2 = '0;
   logic       act1 = 1'b0, act2 = 1'b0;
   always @(posedge clk) begin
      if (rqst_ch1) begin act1 <= 1'b1; idx1 <= '0; end
      else if (act1 && tx_ack_ch1) begin if (idx1 == 2'd3) act1 <= 1'b0; else idx1 <= idx1 + 2'd1; end
      if (rqst_ch2) begin act2 <= 1'b1; idx2 <= '0; end
      else if (act2 && tx_ack_ch2) begin if (idx2 == 2'd3) act2 <= 1'b0; else idx2 <= idx2 + 2'd1; end
   end
   assign tx_rdy_ch1  = act1;
   assign tx_rdy_ch2  = act2;
   assign tx_data_ch1 = ch1_bytes[idx1];
   assign tx_data_ch2 = ch2_bytes[idx2];
   assign tx_eof_ch1  = act1 && idx1 == 2'd3;
   assign tx_eof_ch2  = act2 && idx2 == 2'd3;

   task automatic push(input int k, input logic [7:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic got(input int k, input logic [7:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: unexpected event kind %0d val %h (queue empty)", k, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val != v) begin
            errors++;
            $display("FAIL scoreboard: got kind %0d val %h, expected kind %0d val %h", k, v, e.kind, e.val);
         end
      end
   endtask

   // monitor: every observable DUT event is matched against the expected queue
   logic bf_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (rqst_ch1) got(EV_R1, 8'h00);
         if (rqst_ch2) got(EV_R2, 8'h00);
         if (buffer_full && !bf_prev) got(EV_BF, 8'h00);
         if (tx_rdy && tx_ack) got(EV_TX, tx_data);
      end
      bf_prev <= buffer_full;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input int a, input int d);
      step();
      register_addr = 8'(a);
      register_data = 16'(d);
      register_rdy  = 1'b1;
      step();
      register_rdy  = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check({tag, "_we"}, we, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_tx_rdy"}, tx_rdy, 0);
      check({tag, "_buffer_full"}, buffer_full, 0);
   endtask

   task automatic run_capture(input int num, input int pt, input int t1, input int t2, input int exp_we);
      int   n;
      logic done;
      n = 0;
      done = 1'b0;
      bus(6, num);
      bus(7, pt);
      push(EV_BF, 8'h00);
      bus(5, 1);
      for (int i = 1; i <= 100 && !done; i++) begin
         step();
         adc_rdy_i = 1'b1;
         trigger_i = (i == t1) || (i == t2);
         @(negedge clk);
         if (buffer_full) done = 1'b1;
         else if (we) n++;
      end
      step();
      adc_rdy_i = 1'b0;
      trigger_i = 1'b0;
      check("capture_done", done, 1);
      check("we_strobes", n, exp_we);
      @(negedge clk);
      check("done_we", we, 0);
      check("done_busy", busy, 0);
      check("done_full", buffer_full, 1);
   endtask

   initial begin
      int   fin;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_we", we, 0);
      check("rst_rqst1", rqst_ch1, 0);
      check("rst_rqst2", rqst_ch2, 0);
      check("rst_tx_rdy", tx_rdy, 0);
      check("rst_tx_eof", tx_eof, 0);
      check("rst_ack1", tx_ack_ch1, 0);
      check("rst_ack2", tx_ack_ch2, 0);
      check("rst_full", buffer_full, 0);
      check("rst_busy", busy, 0);
      check("rst_num", num_samples, 16'd1024);
      step();
      rst = 1'b0;
      tx_ack = 1'b0;
      run_capture(8, 3, 6, 0, 10);
      check("num_latched", num_samples, 8);
      run_capture(4, 0, 1, 0, 4);
      run_capture(10, 20, 2, 11, 11);
      // dual readout with stalling ack
      push(EV_R1, 8'h00);
      for (int i = 0; i < 4; i++) push(EV_TX, ch1_bytes[i]);
      push(EV_R2, 8'h00);
      for (int i = 0; i < 4; i++) push(EV_TX, ch2_bytes[i]);
      bus(5, 12);
      fin = 0;
      for (int i = 1; i <= 200 && fin == 0; i++) begin
         step();
         tx_ack = (i % 3) != 0;
         @(negedge clk);
         if (!busy) fin = 1;
      end
      step();
      tx_ack = 1'b0;
      check("read_finished", fin, 1);
      check("read_full_kept", buffer_full, 1);
      check("read_queue_empty", exp_q.size(), 0);
      // STOP (with START) mid-POSTTRIG
      bus(6, 8);
      bus(7, 0);
      bus(5, 1);
      step();
      adc_rdy_i = 1'b1;
      trigger_i = 1'b1;
      step();
      trigger_i = 1'b0;
      step();
      @(negedge clk);
      check("post_busy", busy, 1);
      check("post_we", we, 1);
      bus(5, 3);
      check_idle("stop_post");
      adc_rdy_i = 1'b0;
      // STOP (with READ) mid-SEND_CH1
      run_capture(2, 0, 1, 0, 2);
      push(EV_R1, 8'h00);
      bus(5, 4);
      step();
      @(negedge clk);
      check("send_tx_rdy", tx_rdy, 1);
      check("send_tx_data", tx_data, 8'hA0);
      check("send_tx_eof", tx_eof, 0);
      check("send_full", buffer_full, 1);
      bus(5, 6);
      check_idle("stop_send");
      // zero sample count and mid-capture config write
      bus(6, 0);
      bus(5, 1);
      @(negedge clk);
      check("num_zero_as_one", num_samples, 1);
      check("wait_busy", busy, 1);
      bus(6, 9);
      @(negedge clk);
      check("num_mid_write", num_samples, 1);
      // reset in WAIT_TRIG with START on the same cycle
      bus(6, 4);
      step();
      rst = 1'b1;
      register_addr = 8'd5;
      register_data = 16'd1;
      register_rdy  = 1'b1;
      step();
      rst = 1'b0;
      register_rdy = 1'b0;
      @(negedge clk);
      check("rst2_we", we, 0);
      check("rst2_busy", busy, 0);
      check("rst2_full", buffer_full, 0);
      check("rst2_num", num_samples, 16'd1024);
      step();
      @(negedge clk);
      check("rst2_busy_after", busy, 0);
      check("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
